// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL supervisor: FSM state encoding and
// sizing of the single shared cycle timer.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  // Bits needed to count 0..max(a,b,c)-1.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to zero.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// PLL reset/lock supervisor: holds the PLL in reset, waits for lock with a
// timeout and retries, qualifies lock stability and raises a registered ready.
module pll_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int LOSS_CNT_W          = 8
) (
  input  logic                             refclk,
  input  logic                             rst,
  input  logic                             pll_locked,
  input  logic                             restart,
  output logic                             pll_rst,
  output logic                             ready,
  output logic                             fail,
  output logic [2:0]                       state,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
  output logic [LOSS_CNT_W-1:0]            loss_cnt
);

  localparam int TW = timer_width(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  // The WAIT_LOCK cycle that first sees lock_s counts as qualified cycle one.
  localparam int STABLE_LAST = (LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0;

  logic                  lock_s;
  pll_state_e            state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [RW-1:0]         retry_q, retry_d, retry_inc;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  pll_rst_q, pll_rst_d;
  logic                  ready_q, ready_d;
  logic                  fail_q, fail_d;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i  (refclk),
    .rst_ni (rst),
    .d_i    (pll_locked),
    .q_o    (lock_s)
  );

  assign retry_inc = retry_q + RW'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (restart) begin
      state_d = HOLD;
      timer_d = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (timer_q == TW'(RST_HOLD_CYCLES - 1)) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = (LOCK_STABLE_CYCLES == 1) ? RUN : STABLE;
            timer_d = '0;
            if (LOCK_STABLE_CYCLES == 1) retry_d = '0;
          end else if (timer_q == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RW'(MAX_RETRIES)) ? FAIL : HOLD;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == TW'(STABLE_LAST)) begin
            state_d = RUN;
            timer_d = '0;
            retry_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d = HOLD;
            timer_d = '0;
            if (loss_q != {LOSS_CNT_W{1'b1}}) loss_d = loss_q + LOSS_CNT_W'(1);
          end
        end
        FAIL: begin
          timer_d = '0;
        end
        default: begin
          state_d = HOLD;
          timer_d = '0;
        end
      endcase
    end
    // Outputs are decoded from the next state so they register on the same edge.
    pll_rst_d = (state_d == HOLD) || (state_d == FAIL);
    ready_d   = (state_d == RUN);
    fail_d    = (state_d == FAIL);
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q   <= HOLD;
      timer_q   <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: doc/pll_supervisor.md
Name: pll_supervisor

Overview:
- Controls the far end of the PLL core's rst/locked interface: drives the PLL reset and consumes the PLL lock indication.
- Sequences PLL reset, waits for lock with a timeout, qualifies lock stability, then raises a clean `ready` for downstream reset release.
- Retries on timeout; escalates to a sticky fail state after a set number of retries; counts lock-loss events.
- Runs entirely on the 50 MHz reference clock that also feeds the PLL.

Parameters:
- RST_HOLD_CYCLES, 16, number of refclk cycles `pll_rst` is held high per attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 50000, cycles allowed in WAIT_LOCK before the attempt is declared failed (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before `ready`.
- MAX_RETRIES, 3, failed attempts tolerated before FAIL (>=1).
- LOSS_CNT_W, 8, width of the saturating lock-loss counter.

Ports:
- refclk  in  1  single clock, 50 MHz reference.
- rst  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL lock flag; asynchronous to refclk.
- restart  in  1  synchronous single-cycle request to re-run the sequence from HOLD.
- pll_rst  out  1  reset to the PLL, active-high.
- ready  out  1  PLL locked and qualified.
- fail  out  1  sticky; retries exhausted.
- state  out  3  encoded FSM state, for debug.
- retry_cnt  out  $clog2(MAX_RETRIES+1)  number of failed attempts since the last success or restart.
- loss_cnt  out  LOSS_CNT_W  count of RUN-state lock losses; saturating.

Behaviour:
- Reset (rst=0, async): state=HOLD, pll_rst=1, ready=0, fail=0, retry_cnt=0, loss_cnt=0, all timers=0. All outputs are registered.
- Synchronizer: pll_locked passes through a 2-flop synchronizer to produce lock_s. Latency is 2 cycles. The FSM uses only lock_s.
- HOLD:
  - pll_rst=1. The timer counts 0..RST_HOLD_CYCLES-1.
  - At terminal count: go to WAIT_LOCK, clear the timer.
- WAIT_LOCK:
  - pll_rst=0.
  - lock_s=1: go to STABLE, clear the timer.
  - Otherwise, if timer == LOCK_TIMEOUT_CYCLES-1: retry_cnt+1. If the new value == MAX_RETRIES, go to FAIL; else go to HOLD.
- STABLE:
  - The counter increments each cycle lock_s=1.
  - lock_s=0: go to WAIT_LOCK with a fresh timeout timer. retry_cnt is unchanged.
  - Count == LOCK_STABLE_CYCLES-1 with lock_s=1: go to RUN, clear retry_cnt, register ready=1 on the same edge.
- RUN:
  - ready=1.
  - lock_s=0: ready=0 and state=HOLD on the same edge; loss_cnt+1, saturating at all-ones.
- FAIL:
  - pll_rst=1, fail=1, ready=0.
  - Leaves only on restart.
- restart=1, any state:
  - Highest priority (below async reset).
  - Next state HOLD; timers cleared, retry_cnt cleared, fail cleared. loss_cnt is NOT incremented.
- Lock-to-ready latency: 2 (sync) + LOCK_STABLE_CYCLES cycles from the pll_locked rise to the ready rise, given lock_s is already in WAIT_LOCK.
- Simultaneous events:
  - Timeout and lock_s rising in the same cycle: lock wins (go to STABLE).
  - restart and lock loss in RUN: restart wins; loss_cnt is unchanged.
- pll_locked glitch shorter than 1 cycle may be missed; that is acceptable.
- Reset mid-operation returns immediately to the reset values listed above.

Decomposition:
- Package pll_sup_pkg holds:
  - state enum: HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4;
  - a timer-width helper function.
- Sub-module sync_2ff (parameterized width, async active-low reset to 0) is used for pll_locked.
- One shared timer is muxed by state. Its width is derived from the largest of the three cycle parameters.

Test Plan (params RST_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2):
- Clean bring-up: release rst; assert pll_locked 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; ready rises 2+8=10 cycles after pll_locked; retry_cnt=0.
- Timeout/retry: pll_locked held 0 -> two 4-cycle pll_rst pulses, each followed by 32 cycles low; retry_cnt 1 then 2; FAIL with fail=1 and pll_rst=1; restart -> fail=0, retry_cnt=0, HOLD.
- Unstable lock: in STABLE, drop pll_locked after 5 cycles -> back to WAIT_LOCK, ready stays 0; reassert and hold -> ready after full 8 qualified cycles.
- Lock loss in RUN: drop pll_locked -> ready falls 3 cycles later (2 sync + 1), loss_cnt=1, pll_rst pulses 4 cycles; repeat 300x -> loss_cnt saturates at 255.
- Priority: restart in the same cycle as RUN lock loss -> HOLD, loss_cnt unchanged. Timeout coinciding with lock_s rise -> STABLE, retry_cnt unchanged.
- Async reset mid-STABLE: rst low asynchronously -> all outputs at reset values without waiting for a clock edge.
